esm_issue_scheduler: RTL and testbench
======================================

// Module: esm_issue_scheduler
// PURPOSE
//  Downstream of the ESM dependency-analysis core. Consumes its per-entry ready mask, tracks
//  occupancy of the bs-entry instruction buffer, and issues one dependency-free entry per
//  cycle to the execution unit over a valid/ready handshake, using round-robin selection.
//  Frees entries on completion and reports a free slot to the upstream allocator.
// PARAMETERS
//  bs   16   instruction-buffer entries; power of two, >= 2
//  IW   $clog2(bs)   index width (localparam, not overridable)
// PORTS
//  clk             in   1    clock, rising edge
//  rst             in   1    asynchronous, active-low reset
//  ready_index     in   bs   bit i = entry i has no outstanding dependencies
//  alloc_valid     in   1    upstream writes an instruction into alloc_index this cycle
//  alloc_index     in   IW   entry being allocated
//  issue_valid     out  1    issue_index holds an entry offered to execution
//  issue_index     out  IW   entry being issued
//  issue_ready     in   1    execution unit accepts the offered entry
//  complete_valid  in   1    execution finished entry complete_index
//  complete_index  in   IW   entry completing
//  free_valid      out  1    at least one FREE entry exists
//  free_index      out  IW   lowest-numbered FREE entry (combinational)
//  occupied        out  bs   bit i = entry i not FREE
//  err             out  1    sticky protocol-error flag
// BEHAVIOUR
//  - Reset (rst=0, async): all entries FREE, rr pointer=0, issue_valid=0, issue_index=0,
//    err=0; hence occupied=0, free_valid=1, free_index=0.
//  - Per-entry state: FREE -> WAITING (alloc) -> ISSUED (issue handshake) -> FREE (complete).
//  - eligible[i] = (state==WAITING) & ready_index[i].
//  - Selection: first eligible entry at or after rr pointer, wrapping bs-1 -> 0.
//  - Offer register: if issue_valid=0 and any eligible, next cycle issue_valid=1 with the
//    selected index (1-cycle latency from eligibility to offer). Selected entry is locked:
//    issue_index stable and issue_valid held until issue_ready=1, even if ready_index drops.
//  - Handshake (issue_valid & issue_ready): entry -> ISSUED, rr pointer <= issue_index+1 (mod
//    bs); in the same cycle a new selection (excluding the issued entry) may load the offer
//    register, giving back-to-back issue at one per cycle.
//  - Complete: ISSUED entry -> FREE at next edge. complete on non-ISSUED entry: ignored, err=1.
//  - Alloc: FREE entry -> WAITING at next edge. alloc to non-FREE entry: ignored, err=1.
//  - Alloc and complete same cycle, different indices: both applied. Same index: complete
//    applies (entry FREE); alloc counts as error (err=1) since entry not FREE at sample.
//  - Alloc of an entry also being chosen in that cycle is impossible (FREE not eligible).
//  - Full buffer: free_valid=0, free_index=0; alloc_valid while full -> err=1.
//  - err clears only on reset. Reset mid-handshake drops the offer; no partial state.
// STRUCTURE
//  - Shared package esm_pkg: entry-state enum {FREE, WAITING, ISSUED} (2-bit), BS default,
//    index-width function; shared with the dependency core and allocator.
//  - One sub-module: esm_rr_arbiter (bs-wide mask + pointer -> grant valid/index, combinational,
//    rotate/priority-encode/unrotate). Lowest-free encoder stays inline.
// TESTING
//  1 Reset: assert rst=0 mid-offer -> issue_valid=0, occupied=0, free_index=0, err=0.
//  2 Alloc 0,1,2; ready_index=16'h0006, issue_ready=1 -> issue 1 then 2 on consecutive cycles;
//    entry 0 never issued until ready_index[0]=1.
//  3 Backpressure: offer entry 5, issue_ready=0 for 4 cycles, drop ready_index[5] -> index 5
//    held, issue_valid stays 1; accept on cycle 5 -> occupied[5]=1, state ISSUED.
//  4 Round-robin wrap: entries 15,0,3 all eligible, pointer=15 -> order 15, 0, 3.
//  5 Fill all 16 -> free_valid=0; alloc_valid again -> err=1; complete 7 -> free_index=7.
//  6 Same-cycle alloc 4 / complete 4 (ISSUED) -> entry 4 FREE, err=1; alloc 6 / complete 4
//    -> entry 6 WAITING, entry 4 FREE, err unchanged.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared ESM definitions: per-entry buffer state, default buffer depth and
// the index-width helper. Used by the dependency core, the allocator and the
// issue scheduler so all of them agree on encodings and widths.
package esm_pkg;

  // Lifecycle of one instruction-buffer entry
  typedef enum logic [1:0] {
    ENTRY_FREE    = 2'd0,
    ENTRY_WAITING = 2'd1,
    ENTRY_ISSUED  = 2'd2
  } entry_state_e;

  localparam int BS = 16;

  // Index width for an n-entry buffer (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/esm_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   mask        : requesting entries
//   ptr         : highest-priority position this cycle
//   grant_valid : at least one request
//   grant_index : first requesting entry at or after ptr, wrapping bs-1 -> 0
// Works by rotating the mask so ptr lands at bit 0, priority-encoding the
// lowest set bit, then adding ptr back. The add wraps for free because bs is
// a power of two.
module esm_rr_arbiter
  import esm_pkg::*;
#(
  parameter int  bs = BS,
  localparam int IW = idx_width(bs)
) (
  input  logic [bs-1:0] mask,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_index
);

  logic [2*bs-1:0] dbl_s;
  logic [bs-1:0]   rot_s;
  logic [IW-1:0]   off_s;

  // Rotate, priority-encode lowest request, unrotate
  always_comb begin
    dbl_s = {mask, mask} >> ptr;
    rot_s = dbl_s[bs-1:0];
    off_s = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IW'(i) : off_s;
    end
    grant_valid = |rot_s;
    grant_index = off_s + ptr;
  end

endmodule

// File: rtl/esm_issue_scheduler.sv
// ESM issue scheduler. Tracks the state of every instruction-buffer entry,
// offers one dependency-free entry per cycle to execution (round-robin),
// frees entries on completion and reports the lowest free slot upstream.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   ready_index[bs]          per-entry "no outstanding dependencies"
//   alloc_valid/alloc_index  upstream writes an entry
//   issue_valid/issue_index  registered offer to execution
//   issue_ready              execution accepts the offer
//   complete_valid/_index    execution finished an entry
//   free_valid/free_index    lowest FREE entry (index 0 when none)
//   occupied[bs]             entry is not FREE
//   err                      sticky protocol error (bad alloc/complete)
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter int  bs = BS,
  localparam int IW = idx_width(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [bs-1:0] ready_index,
  input  logic          alloc_valid,
  input  logic [IW-1:0] alloc_index,
  output logic          issue_valid,
  output logic [IW-1:0] issue_index,
  input  logic          issue_ready,
  input  logic          complete_valid,
  input  logic [IW-1:0] complete_index,
  output logic          free_valid,
  output logic [IW-1:0] free_index,
  output logic [bs-1:0] occupied,
  output logic          err
);

  entry_state_e  state_r   [bs];
  entry_state_e  state_nxt_s [bs];
  logic [bs-1:0] eligible_s;
  logic [bs-1:0] mask_s;
  logic [IW-1:0] rr_ptr_r;
  logic [IW-1:0] rr_ptr_nxt_s;
  logic [IW-1:0] ptr_s;
  logic          issue_valid_r;
  logic          issue_valid_nxt_s;
  logic [IW-1:0] issue_index_r;
  logic [IW-1:0] issue_index_nxt_s;
  logic          err_r;
  logic          err_nxt_s;
  logic          handshake_s;
  logic          load_s;
  logic          grant_valid_s;
  logic [IW-1:0] grant_index_s;
  logic          alloc_err_s;
  logic          complete_err_s;

  assign issue_valid = issue_valid_r;
  assign issue_index = issue_index_r;
  assign err         = err_r;
  assign handshake_s = issue_valid_r & issue_ready;

  // Eligibility, arbiter inputs, occupancy and lowest-free encoding
  always_comb begin
    free_valid = 1'b0;
    free_index = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      eligible_s[i] = (state_r[i] == ENTRY_WAITING) & ready_index[i];
      occupied[i]   = (state_r[i] != ENTRY_FREE);
      free_index    = (state_r[i] == ENTRY_FREE) ? IW'(i) : free_index;
      free_valid    = free_valid | (state_r[i] == ENTRY_FREE);
    end
    // On a handshake the accepted entry is still WAITING this cycle, so it
    // must be masked out, and the search restarts just past it.
    mask_s = eligible_s;
    if (handshake_s) begin
      mask_s[issue_index_r] = 1'b0;
      ptr_s                 = issue_index_r + IW'(1);
    end else begin
      ptr_s                 = rr_ptr_r;
    end
  end

  esm_rr_arbiter #(.bs(bs)) u_arb (
    .mask        (mask_s),
    .ptr         (ptr_s),
    .grant_valid (grant_valid_s),
    .grant_index (grant_index_s)
  );

  // Per-entry next state, offer register next value and error detection
  always_comb begin
    for (int i = 0; i < bs; i++) begin
      case (state_r[i])
        ENTRY_FREE: begin
          if (alloc_valid && (alloc_index == IW'(i))) state_nxt_s[i] = ENTRY_WAITING;
          else                                        state_nxt_s[i] = ENTRY_FREE;
        end
        ENTRY_WAITING: begin
          if (handshake_s && (issue_index_r == IW'(i))) state_nxt_s[i] = ENTRY_ISSUED;
          else                                          state_nxt_s[i] = ENTRY_WAITING;
        end
        ENTRY_ISSUED: begin
          if (complete_valid && (complete_index == IW'(i))) state_nxt_s[i] = ENTRY_FREE;
          else                                              state_nxt_s[i] = ENTRY_ISSUED;
        end
        default: state_nxt_s[i] = ENTRY_FREE;
      endcase
    end

    alloc_err_s    = alloc_valid    && (state_r[alloc_index]    != ENTRY_FREE);
    complete_err_s = complete_valid && (state_r[complete_index] != ENTRY_ISSUED);
    err_nxt_s      = err_r | alloc_err_s | complete_err_s;

    // The offer is locked until accepted; only reload when empty or consumed
    load_s = ~issue_valid_r | handshake_s;
    if (load_s) begin
      issue_valid_nxt_s = grant_valid_s;
      issue_index_nxt_s = grant_valid_s ? grant_index_s : issue_index_r;
    end else begin
      issue_valid_nxt_s = issue_valid_r;
      issue_index_nxt_s = issue_index_r;
    end

    if (handshake_s) rr_ptr_nxt_s = issue_index_r + IW'(1);
    else             rr_ptr_nxt_s = rr_ptr_r;
  end

  // State, offer, pointer and error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < bs; i++) state_r[i] <= ENTRY_FREE;
      rr_ptr_r      <= '0;
      issue_valid_r <= 1'b0;
      issue_index_r <= '0;
      err_r         <= 1'b0;
    end else begin
      for (int i = 0; i < bs; i++) state_r[i] <= state_nxt_s[i];
      rr_ptr_r      <= rr_ptr_nxt_s;
      issue_valid_r <= issue_valid_nxt_s;
      issue_index_r <= issue_index_nxt_s;
      err_r         <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
module tb_esm_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ready_index;
  logic        alloc_valid;
  logic [3:0]  alloc_index;
  logic        issue_valid;
  logic [3:0]  issue_index;
  logic        issue_ready;
  logic        complete_valid;
  logic [3:0]  complete_index;
  logic        free_valid;
  logic [3:0]  free_index;
  logic [15:0] occupied;
  logic        err;

  int checks = 0;
  int errors = 0;

  esm_issue_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .ready_index    (ready_index),
    .alloc_valid    (alloc_valid),
    .alloc_index    (alloc_index),
    .issue_valid    (issue_valid),
    .issue_index    (issue_index),
    .issue_ready    (issue_ready),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .free_valid     (free_valid),
    .free_index     (free_index),
    .occupied       (occupied),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic alloc(input logic [3:0] idx);
    alloc_valid = 1'b1;
    alloc_index = idx;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [3:0] idx);
    complete_valid = 1'b1;
    complete_index = idx;
    tick();
    complete_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ready_index = '0; alloc_valid = 1'b0; alloc_index = '0;
    issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: reset state, then reset in the middle of a pending offer
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_occupied",    32'(occupied),    32'd0);
    chk("rst_free_valid",  32'(free_valid),  32'd1);
    chk("rst_free_index",  32'(free_index),  32'd0);
    chk("rst_err",         32'(err),         32'd0);
    ready_index = 16'h0008;
    alloc(4'd3);
    tick();
    chk("pre_offer_valid", 32'(issue_valid), 32'd1);
    chk("pre_offer_index", 32'(issue_index), 32'd3);
    chk("pre_free_index",  32'(free_index),  32'd0);
    complete(4'd9);
    chk("bad_complete_err", 32'(err), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_issue_valid", 32'(issue_valid), 32'd0);
    chk("midrst_occupied",    32'(occupied),    32'd0);
    chk("midrst_free_index",  32'(free_index),  32'd0);
    chk("midrst_err",         32'(err),         32'd0);
    rst = 1'b1;
    ready_index = '0;
    tick();

    // 2: back-to-back issue of 1 then 2; entry 0 waits for its ready bit
    ready_index = 16'h0006;
    issue_ready = 1'b1;
    alloc(4'd0);
    alloc(4'd1);
    alloc(4'd2);
    chk("b2b_first_valid", 32'(issue_valid), 32'd1);
    chk("b2b_first_index", 32'(issue_index), 32'd1);
    tick();
    chk("b2b_second_valid", 32'(issue_valid), 32'd1);
    chk("b2b_second_index", 32'(issue_index), 32'd2);
    tick();
    chk("b2b_idle", 32'(issue_valid), 32'd0);
    tick();
    chk("b2b_e0_not_issued", 32'(issue_valid), 32'd0);
    chk("b2b_occupied",      32'(occupied),    32'h0007);
    ready_index = 16'h0007;
    tick();
    chk("e0_offer_valid", 32'(issue_valid), 32'd1);
    chk("e0_offer_index", 32'(issue_index), 32'd0);
    tick();
    chk("e0_accepted", 32'(issue_valid), 32'd0);
    ready_index = '0;
    complete(4'd0);
    complete(4'd1);
    complete(4'd2);
    chk("t2_drain_occupied", 32'(occupied), 32'd0);
    chk("t2_drain_err",      32'(err),      32'd0);

    // 3: backpressure holds offer of entry 5 even after its ready bit drops
    issue_ready = 1'b0;
    ready_index = 16'h0020;
    alloc(4'd5);
    tick();
    chk("bp_offer_valid", 32'(issue_valid), 32'd1);
    chk("bp_offer_index", 32'(issue_index), 32'd5);
    ready_index = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_hold_valid", 32'(issue_valid), 32'd1);
    chk("bp_hold_index", 32'(issue_index), 32'd5);
    issue_ready = 1'b1;
    tick();
    chk("bp_accept_valid",    32'(issue_valid), 32'd0);
    chk("bp_accept_occupied", 32'(occupied),    32'h0020);
    complete(4'd5);
    chk("bp_issued_complete_err", 32'(err),      32'd0);
    chk("bp_issued_complete_occ", 32'(occupied), 32'd0);

    // 4: round-robin wrap; move pointer to 15 by issuing entry 14 first
    ready_index = 16'h4000;
    alloc(4'd14);
    tick();
    chk("rr_e14_index", 32'(issue_index), 32'd14);
    tick();
    chk("rr_e14_done", 32'(issue_valid), 32'd0);
    ready_index = '0;
    complete(4'd14);
    alloc(4'd15);
    alloc(4'd0);
    alloc(4'd3);
    ready_index = 16'h8009;
    tick();
    chk("rr_order0", 32'(issue_index), 32'd15);
    tick();
    chk("rr_order1", 32'(issue_index), 32'd0);
    tick();
    chk("rr_order2", 32'(issue_index), 32'd3);
    tick();
    chk("rr_done", 32'(issue_valid), 32'd0);
    ready_index = '0;
    complete(4'd15);
    complete(4'd0);
    complete(4'd3);
    chk("rr_drain_occupied", 32'(occupied), 32'd0);
    chk("rr_drain_err",      32'(err),      32'd0);

    // 5: full buffer, alloc while full, then completion frees entry 7
    issue_ready = 1'b0;
    for (int i = 0; i < 16; i++) alloc(4'(i));
    chk("full_occupied",   32'(occupied),   32'hFFFF);
    chk("full_free_valid", 32'(free_valid), 32'd0);
    chk("full_free_index", 32'(free_index), 32'd0);
    chk("full_err_clean",  32'(err),        32'd0);
    ready_index = 16'h0080;
    issue_ready = 1'b1;
    tick();
    chk("full_offer7", 32'(issue_index), 32'd7);
    tick();
    ready_index = '0;
    issue_ready = 1'b0;
    chk("full_still_full", 32'(free_valid), 32'd0);
    alloc(4'd2);
    chk("full_alloc_err", 32'(err), 32'd1);
    complete(4'd7);
    chk("full_free_after7",  32'(free_valid), 32'd1);
    chk("full_free_index7",  32'(free_index), 32'd7);
    chk("full_occupied_n7",  32'(occupied),   32'hFF7F);

    // 6a: same-cycle alloc 4 / complete 4 (ISSUED)
    do_reset();
    tick();
    ready_index = 16'h0010;
    issue_ready = 1'b1;
    alloc(4'd4);
    tick();
    tick();
    ready_index = '0;
    chk("same_pre_occ", 32'(occupied), 32'h0010);
    chk("same_pre_err", 32'(err),      32'd0);
    alloc_valid = 1'b1; alloc_index = 4'd4;
    complete_valid = 1'b1; complete_index = 4'd4;
    tick();
    alloc_valid = 1'b0; complete_valid = 1'b0;
    chk("same_idx_occ", 32'(occupied), 32'd0);
    chk("same_idx_err", 32'(err),      32'd1);

    // 6b: alloc 6 / complete 4 in the same cycle
    do_reset();
    tick();
    ready_index = 16'h0010;
    alloc(4'd4);
    tick();
    tick();
    ready_index = '0;
    alloc_valid = 1'b1; alloc_index = 4'd6;
    complete_valid = 1'b1; complete_index = 4'd4;
    tick();
    alloc_valid = 1'b0; complete_valid = 1'b0;
    chk("diff_idx_occ", 32'(occupied), 32'h0040);
    chk("diff_idx_err", 32'(err),      32'd0);
    ready_index = 16'h0040;
    tick();
    chk("diff_e6_waiting_valid", 32'(issue_valid), 32'd1);
    chk("diff_e6_waiting_index", 32'(issue_index), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
